cpu_id: RTL

- Instruction-decode stage of the 5-stage PLP MIPS pipeline; consumes p_pc/p_inst from the fetch stage.
- Reads the register file, decodes control, and resolves j/jal/jr/jalr (pc_j, j_addr back to fetch).
- Detects load-use and jump-register hazards (stall to fetch) and registers the ID/EX pipeline bundle.
- Taken branches are resolved in EX; pc_b_in squashes the ID instruction.

---
 rtl/cpu_defs.sv | 74 +++++++
 rtl/cpu_id_if.sv | 51 +++++
 rtl/cpu_regfile.sv | 30 +++
 rtl/cpu_id.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared decode constants and the ID/EX bundle type for the PLP MIPS
// instruction-decode stage.
package cpu_defs;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_NOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_LUI  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10
    } br_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rf_a;
        logic [31:0] rf_b;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        alusrc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        br_e         br;
        logic [31:0] b_addr;
        logic        link;
    } id_ex_t;

endpackage

// File: rtl/cpu_id_if.sv
// Decode-stage boundary: fetch inputs, forwarding/hazard sideband,
// writeback port, fetch control and the registered ID/EX bundle.
interface cpu_id_if;
    logic [31:0] p_pc;
    logic [31:0] p_inst;
    logic        pc_b_in;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        stall;
    logic        pc_j;
    logic [31:0] j_addr;
    logic [31:0] q_pc;
    logic [31:0] q_rf_a;
    logic [31:0] q_rf_b;
    logic [31:0] q_imm;
    logic [4:0]  q_shamt;
    logic [4:0]  q_rs;
    logic [4:0]  q_rt;
    logic [4:0]  q_rd;
    logic [3:0]  q_alu_op;
    logic        q_alusrc;
    logic        q_regwrite;
    logic        q_memread;
    logic        q_memwrite;
    logic [1:0]  q_br;
    logic [31:0] q_b_addr;
    logic        q_link;

    modport master (
        output p_pc, p_inst, pc_b_in, ex_regwrite, ex_memread, ex_rd,
               mem_regwrite, mem_rd, wb_we, wb_addr, wb_data,
        input  stall, pc_j, j_addr, q_pc, q_rf_a, q_rf_b, q_imm, q_shamt,
               q_rs, q_rt, q_rd, q_alu_op, q_alusrc, q_regwrite, q_memread,
               q_memwrite, q_br, q_b_addr, q_link
    );

    modport slave (
        input  p_pc, p_inst, pc_b_in, ex_regwrite, ex_memread, ex_rd,
               mem_regwrite, mem_rd, wb_we, wb_addr, wb_data,
        output stall, pc_j, j_addr, q_pc, q_rf_a, q_rf_b, q_imm, q_shamt,
               q_rs, q_rt, q_rd, q_alu_op, q_alusrc, q_regwrite, q_memread,
               q_memwrite, q_br, q_b_addr, q_link
    );
endinterface

// File: rtl/cpu_regfile.sv
// 32x32 register file: two async reads, one sync write, r0 hardwired to
// zero, and a same-cycle bypass of the writeback value.
module cpu_regfile (
    input  logic        clk,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);
    logic [31:0] mem_q [32];

    always_ff @(posedge clk) begin
        if (we_i && wa_i != 5'd0) mem_q[wa_i] <= wd_i;
    end

    always_comb begin
        rd1_o = mem_q[ra1_i];
        if (ra1_i == 5'd0)                rd1_o = 32'd0;
        else if (we_i && wa_i == ra1_i)   rd1_o = wd_i;
    end

    always_comb begin
        rd2_o = mem_q[ra2_i];
        if (ra2_i == 5'd0)                rd2_o = 32'd0;
        else if (we_i && wa_i == ra2_i)   rd2_o = wd_i;
    end
endmodule

// File: rtl/cpu_id.sv
// Instruction-decode stage: register read, control decode, jump resolution,
// load-use / jump-register hazard detection and the ID/EX register.
module cpu_id
    import cpu_defs::*;
(
    input  logic     clk,
    input  logic     rst,
    cpu_id_if.slave  bus
);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, pc4, rf_a, rf_b;

    assign op   = bus.p_inst[31:26];
    assign fn   = bus.p_inst[5:0];
    assign rs   = bus.p_inst[25:21];
    assign rt   = bus.p_inst[20:16];
    assign rd   = bus.p_inst[15:11];
    assign simm = {{16{bus.p_inst[15]}}, bus.p_inst[15:0]};
    assign pc4  = bus.p_pc + 32'd4;

    cpu_regfile u_rf (
        .clk   (clk),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rf_a),
        .rd2_o (rf_b),
        .we_i  (bus.wb_we),
        .wa_i  (bus.wb_addr),
        .wd_i  (bus.wb_data)
    );

    logic   valid, reads_rt, is_jr, is_jimm, has_dest;
    logic [4:0] dest;
    id_ex_t dec;

    always_comb begin
        valid    = 1'b1;
        reads_rt = 1'b0;
        is_jr    = 1'b0;
        is_jimm  = 1'b0;
        has_dest = 1'b0;
        dest     = rd;
        dec        = '0;
        dec.pc     = bus.p_pc;
        dec.rf_a   = rf_a;
        dec.rf_b   = rf_b;
        dec.imm    = simm;
        dec.shamt  = bus.p_inst[10:6];
        dec.rs     = rs;
        dec.rt     = rt;
        dec.b_addr = pc4 + (simm << 2);
        case (op)
            OP_RTYPE: begin
                reads_rt = 1'b1;
                has_dest = 1'b1;
                case (fn)
                    FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:          dec.alu_op = ALU_AND;
                    FN_OR:           dec.alu_op = ALU_OR;
                    FN_NOR:          dec.alu_op = ALU_NOR;
                    FN_SLT:          dec.alu_op = ALU_SLT;
                    FN_SLTU:         dec.alu_op = ALU_SLTU;
                    FN_SLL:          dec.alu_op = ALU_SLL;
                    FN_SRL:          dec.alu_op = ALU_SRL;
                    FN_JR:   begin is_jr = 1'b1; has_dest = 1'b0; end
                    FN_JALR: begin is_jr = 1'b1; dec.link = 1'b1; end
                    default: valid = 1'b0;
                endcase
            end
            OP_J:   is_jimm = 1'b1;
            OP_JAL: begin
                is_jimm  = 1'b1;
                has_dest = 1'b1;
                dest     = 5'd31;
                dec.link = 1'b1;
            end
            OP_BEQ: begin reads_rt = 1'b1; dec.br = BR_BEQ; dec.alu_op = ALU_SUB; end
            OP_BNE: begin reads_rt = 1'b1; dec.br = BR_BNE; dec.alu_op = ALU_SUB; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                has_dest   = 1'b1;
                dest       = rt;
                dec.alusrc = 1'b1;
                case (op)
                    OP_SLTI:  dec.alu_op = ALU_SLT;
                    OP_SLTIU: dec.alu_op = ALU_SLTU;
                    OP_ANDI:  begin dec.alu_op = ALU_AND; dec.imm = {16'd0, bus.p_inst[15:0]}; end
                    OP_ORI:   begin dec.alu_op = ALU_OR;  dec.imm = {16'd0, bus.p_inst[15:0]}; end
                    OP_LUI:   begin dec.alu_op = ALU_LUI; dec.imm = {bus.p_inst[15:0], 16'd0}; end
                    OP_LW:    begin dec.alu_op = ALU_ADD; dec.memread = 1'b1; end
                    default:  dec.alu_op = ALU_ADD;
                endcase
            end
            OP_SW: begin
                reads_rt     = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec.alu_op   = ALU_ADD;
            end
            default: valid = 1'b0;
        endcase
        if (bus.p_inst == NOP_INST) valid = 1'b0;
        dec.rd       = has_dest ? dest : 5'd0;
        dec.regwrite = has_dest && (dest != 5'd0);
    end

    // jr/jalr must wait until the producer of rs is in WB, where the
    // register file bypass delivers it.
    logic load_use, jr_haz, hazard;
    assign load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == rs) || (reads_rt && bus.ex_rd == rt));
    assign jr_haz   = is_jr && (rs != 5'd0) &&
                      ((bus.ex_regwrite && bus.ex_rd == rs) ||
                       (bus.mem_regwrite && bus.mem_rd == rs));
    assign hazard   = valid && (load_use || jr_haz);

    assign bus.stall  = !bus.pc_b_in && hazard;
    assign bus.pc_j   = !bus.pc_b_in && !hazard && valid && (is_jr || is_jimm);
    assign bus.j_addr = is_jr ? rf_a : {pc4[31:28], bus.p_inst[25:0], 2'b00};

    // ID/EX register
    id_ex_t idex_d, idex_q;
    assign idex_d = (valid && !bus.pc_b_in && !hazard) ? dec : '0;

    always_ff @(posedge clk) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    assign bus.q_pc       = idex_q.pc;
    assign bus.q_rf_a     = idex_q.rf_a;
    assign bus.q_rf_b     = idex_q.rf_b;
    assign bus.q_imm      = idex_q.imm;
    assign bus.q_shamt    = idex_q.shamt;
    assign bus.q_rs       = idex_q.rs;
    assign bus.q_rt       = idex_q.rt;
    assign bus.q_rd       = idex_q.rd;
    assign bus.q_alu_op   = idex_q.alu_op;
    assign bus.q_alusrc   = idex_q.alusrc;
    assign bus.q_regwrite = idex_q.regwrite;
    assign bus.q_memread  = idex_q.memread;
    assign bus.q_memwrite = idex_q.memwrite;
    assign bus.q_br       = idex_q.br;
    assign bus.q_b_addr   = idex_q.b_addr;
    assign bus.q_link     = idex_q.link;
endmodule
